cerradura_ctrl: RTL and testbench

Access controller for the door-lock actuator on the security core bus. Arbitrates unlock requests from three requesters: manual switch, bus command and keypad verdict. Drives the actuator for a fixed open time, enforces a cooldown between openings and applies a lockout after repeated bad keypad codes. Sits between bus decode, keypad comparator and the lock output pin.

---
 rtl/cerradura_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_cerradura_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cerradura_ctrl.sv
// -----------------------------------------------------------------------------
// cerradura_ctrl
// Door-lock access controller for the security core bus. It arbitrates unlock
// requests from the manual switch, the bus and the keypad verdict. It holds the
// actuator open for a fixed time and enforces a cooldown between openings.
// After repeated bad keypad codes it applies a lockout.
//
// Build option:
//   MANUAL_OVERRIDE_EN  When defined, a manual request during LOCKOUT is granted
//                       and also clears the lockout. When undefined, manual
//                       requests during LOCKOUT are dropped.
//
// Ports:
//   clk         system clock
//   Reset       synchronous, active-high reset
//   en          bus strobe, one cycle per command
//   addr        bus address; the block answers at CORE_ADDR
//   cmd         bus command: 1 UNLOCK, 2 LOCK, 3 CLEAR; other values ignored
//   switch      manual pushbutton, asynchronous level
//   code_valid  one-cycle pulse: a keypad verdict is available
//   code_ok     keypad verdict, sampled when code_valid=1
//   cerr        lock actuator, 1 = open
//   isDone      one-cycle pulse when an opening ends
//   busy        1 whenever the controller is not idle
//   lockout     1 while locked out after bad codes
//   fail_count  consecutive bad codes, saturating at 15
//   grant       source of the current/last opening: 0 none, 1 manual, 2 bus,
//               3 keypad
// -----------------------------------------------------------------------------
module cerradura_ctrl #(
  parameter logic [15:0] CORE_ADDR      = 16'h0016,
  parameter logic [31:0] OPEN_CYCLES    = 32'd150000000,
  parameter logic [31:0] COOL_CYCLES    = 32'd50000000,
  parameter logic [31:0] LOCKOUT_CYCLES = 32'd1500000000,
  parameter logic [3:0]  MAX_FAILS      = 4'd3
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        en,
  input  logic [15:0] addr,
  input  logic [2:0]  cmd,
  input  logic        switch,
  input  logic        code_valid,
  input  logic        code_ok,
  output logic        cerr,
  output logic        isDone,
  output logic        busy,
  output logic        lockout,
  output logic [3:0]  fail_count,
  output logic [1:0]  grant
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_OPEN    = 2'd1;
  localparam logic [1:0] S_COOL    = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam logic [2:0] CMD_UNLOCK = 3'd1;
  localparam logic [2:0] CMD_LOCK   = 3'd2;
  localparam logic [2:0] CMD_CLEAR  = 3'd3;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_MANUAL = 2'd1;
  localparam logic [1:0] SRC_BUS    = 2'd2;
  localparam logic [1:0] SRC_KEYPAD = 2'd3;

  // ---------------------------------------------------------------------------
  // Manual switch: 2-flop synchronizer, then a registered rising-edge pulse.
  // The request is therefore seen 3 cycles after the pin rises. A held switch
  // produces only one request.
  // ---------------------------------------------------------------------------
  logic sw_meta_q, sw_sync_q, sw_prev_q, man_req_q;

  // NOTE: all clocked state uses non-blocking assignments. Every flop then
  //       samples the values from before the edge, which is what makes this
  //       chain behave as a shift register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
      sw_prev_q <= 1'b0;
      man_req_q <= 1'b0;
    end else begin
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      sw_prev_q <= sw_sync_q;
      man_req_q <= sw_sync_q & ~sw_prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic bus_hit, bus_unlock, bus_lock, bus_clear;

  assign bus_hit    = en && (addr == CORE_ADDR);
  assign bus_unlock = bus_hit && (cmd == CMD_UNLOCK);
  assign bus_lock   = bus_hit && (cmd == CMD_LOCK);
  assign bus_clear  = bus_hit && (cmd == CMD_CLEAR);

  // ---------------------------------------------------------------------------
  // Main FSM with one shared counter. The counter restarts at 0 on every state
  // entry and is compared for exact equality against (length - 1). Each state
  // therefore lasts exactly its parameter value in cycles.
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        isdone_q, isdone_d;
  logic [3:0]  fail_q, fail_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  fail_inc;

  assign fail_inc = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

  // NOTE: every variable gets a default at the top of this block. Without the
  //       defaults, any path that did not assign a variable would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    isdone_d = 1'b0;
    fail_d   = fail_q;
    grant_d  = grant_q;

    case (state_q)
      S_IDLE: begin
        // Fixed priority: manual > bus UNLOCK > keypad. Losing requests are
        // dropped, including keypad verdicts, whether good or bad.
        if (man_req_q) begin
          state_d = S_OPEN;
          cnt_d   = 32'd0;
          grant_d = SRC_MANUAL;
        end else if (bus_unlock) begin
          state_d = S_OPEN;
          cnt_d   = 32'd0;
          grant_d = SRC_BUS;
        end else if (code_valid && code_ok) begin
          state_d = S_OPEN;
          cnt_d   = 32'd0;
          grant_d = SRC_KEYPAD;
          fail_d  = 4'd0;
        end else if (bus_clear) begin
          fail_d = 4'd0;
        end else if (code_valid && !code_ok) begin
          fail_d = fail_inc;
          if (fail_inc == MAX_FAILS) begin
            state_d = S_LOCKOUT;
            cnt_d   = 32'd0;
          end
        end
      end

      S_OPEN: begin
        if (bus_clear) fail_d = 4'd0;
        if (bus_lock || (cnt_q == OPEN_CYCLES - 32'd1)) begin
          state_d  = S_COOL;
          cnt_d    = 32'd0;
          isdone_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_COOL: begin
        if (bus_clear) fail_d = 4'd0;
        if (cnt_q == COOL_CYCLES - 32'd1) begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin  // S_LOCKOUT
`ifdef MANUAL_OVERRIDE_EN
        if (man_req_q) begin
          state_d = S_OPEN;
          cnt_d   = 32'd0;
          grant_d = SRC_MANUAL;
          fail_d  = 4'd0;
        end else
`endif
        if (bus_clear || (cnt_q == LOCKOUT_CYCLES - 32'd1)) begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
          fail_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 32'd0;
      isdone_q <= 1'b0;
      fail_q   <= 4'd0;
      grant_q  <= SRC_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      isdone_q <= isdone_d;
      fail_q   <= fail_d;
      grant_q  <= grant_d;
    end
  end

  // The actuator is open exactly while the FSM is in OPEN. A reset therefore
  // closes the lock at the next edge without raising isDone.
  assign cerr       = (state_q == S_OPEN);
  assign busy       = (state_q != S_IDLE);
  assign lockout    = (state_q == S_LOCKOUT);
  assign isDone     = isdone_q;
  assign fail_count = fail_q;
  assign grant      = grant_q;

endmodule

// File: tb/tb_cerradura_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cerradura_ctrl
// Self-checking bench for cerradura_ctrl with short timing parameters. Each
// scenario task drives a per-cycle stimulus plan. As it drives each cycle, it
// pushes the expected output word for that cycle onto a scoreboard queue. At
// the negative edge it pops the word and compares it with the DUT.
// Output word layout: {cerr, isDone, busy, lockout, fail_count[3:0], grant[1:0]}
// -----------------------------------------------------------------------------
module tb_cerradura_ctrl;

  localparam logic [15:0] ADDR  = 16'h0016;
  localparam logic [31:0] OPEN  = 32'd10;
  localparam logic [31:0] COOL  = 32'd4;
  localparam logic [31:0] LOCK  = 32'd20;
  localparam logic [3:0]  MAXF  = 4'd3;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [2:0]  cmd = 3'd0;
  logic        switch = 1'b0;
  logic        code_valid = 1'b0;
  logic        code_ok = 1'b0;
  logic        cerr, isDone, busy, lockout;
  logic [3:0]  fail_count;
  logic [1:0]  grant;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  sb[$];

  cerradura_ctrl #(
    .CORE_ADDR     (ADDR),
    .OPEN_CYCLES   (OPEN),
    .COOL_CYCLES   (COOL),
    .LOCKOUT_CYCLES(LOCK),
    .MAX_FAILS     (MAXF)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .en        (en),
    .addr      (addr),
    .cmd       (cmd),
    .switch    (switch),
    .code_valid(code_valid),
    .code_ok   (code_ok),
    .cerr      (cerr),
    .isDone    (isDone),
    .busy      (busy),
    .lockout   (lockout),
    .fail_count(fail_count),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  logic [9:0] obs;
  assign obs = {cerr, isDone, busy, lockout, fail_count, grant};

  function automatic logic [9:0] ev(input logic c, input logic d, input logic b,
                                    input logic l, input logic [3:0] f,
                                    input logic [1:0] g);
    return {c, d, b, l, f, g};
  endfunction

  task automatic clear_inputs();
    en = 1'b0; addr = 16'h0000; cmd = 3'd0; code_valid = 1'b0; code_ok = 1'b0;
  endtask

  task automatic bus_cmd(input logic [15:0] a, input logic [2:0] c);
    en = 1'b1; addr = a; cmd = c;
  endtask

  task automatic keypad(input logic ok);
    code_valid = 1'b1; code_ok = ok;
  endtask

  task automatic do_reset();
    clear_inputs();
    switch = 1'b0;
    Reset  = 1'b1;
    repeat (4) @(posedge clk);
    #1 Reset = 1'b0;
  endtask

  // Outputs must be all-zero while Reset is held, starting after the first edge.
  task automatic test_reset();
    logic [9:0] exp_v;
    clear_inputs();
    Reset = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      sb.push_back(10'd0);
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL reset cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    Reset = 1'b0;
  endtask

  // Bus UNLOCK at cycle 0; repeated UNLOCK during COOL, wrong address and
  // unknown command in IDLE must all be ignored.
  task automatic test_bus_unlock();
    logic [9:0] exp_v;
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      clear_inputs();
      if (c == 0 || c == 12) bus_cmd(ADDR, 3'd1);
      if (c == 16) bus_cmd(16'h0017, 3'd1);
      if (c == 17) bus_cmd(ADDR, 3'd5);
      sb.push_back(ev(c >= 1 && c <= 10, c == 11, c >= 1 && c <= 14, 1'b0,
                      4'd0, (c >= 1) ? 2'd2 : 2'd0));
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL bus_unlock cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // Switch held high for 50 cycles: a single opening at cycles 4-13.
  task automatic test_manual();
    logic [9:0] exp_v;
    do_reset();
    for (int c = 0; c <= 55; c++) begin
      clear_inputs();
      switch = (c < 50);
      sb.push_back(ev(c >= 4 && c <= 13, c == 14, c >= 4 && c <= 17, 1'b0,
                      4'd0, (c >= 4) ? 2'd1 : 2'd0));
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL manual cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    switch = 1'b0;
  endtask

  // A bad code first sets fail_count to 1. The manual request, bus UNLOCK and
  // keypad success then all arrive in cycle 5: manual wins, and the dropped
  // keypad success must not clear fail_count. A later keypad success opens the
  // lock on its own and clears fail_count.
  task automatic test_priority();
    logic [9:0] exp_v;
    logic [1:0] g;
    do_reset();
    for (int c = 0; c <= 37; c++) begin
      clear_inputs();
      switch = (c >= 2 && c < 20);
      if (c == 0) keypad(1'b0);
      if (c == 5) begin bus_cmd(ADDR, 3'd1); keypad(1'b1); end
      if (c == 21) keypad(1'b1);
      g = (c < 6) ? 2'd0 : (c < 22) ? 2'd1 : 2'd3;
      sb.push_back(ev((c >= 6 && c <= 15) || (c >= 22 && c <= 31),
                      c == 16 || c == 32,
                      (c >= 6 && c <= 19) || (c >= 22 && c <= 35), 1'b0,
                      (c >= 1 && c < 22) ? 4'd1 : 4'd0, g));
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL priority cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    switch = 1'b0;
  endtask

  // Three bad codes lead to a 20-cycle lockout that ignores UNLOCK, good codes
  // and bad codes. A second lockout is ended by CLEAR at lockout cycle 5.
  // Finally, CLEAR in IDLE zeroes fail_count.
  task automatic test_lockout();
    logic [9:0] exp_v;
    logic [3:0] f;
    logic       lk;
    do_reset();
    for (int c = 0; c <= 44; c++) begin
      clear_inputs();
      if (c == 0 || c == 2 || c == 4) keypad(1'b0);
      if (c == 10) bus_cmd(ADDR, 3'd1);
      if (c == 12) keypad(1'b1);
      if (c == 14) keypad(1'b0);
      if (c == 27 || c == 29 || c == 31) keypad(1'b0);
      if (c == 37) bus_cmd(ADDR, 3'd3);
      if (c == 40) keypad(1'b0);
      if (c == 42) bus_cmd(ADDR, 3'd3);
      lk = (c >= 5 && c <= 24) || (c >= 32 && c <= 37);
      if (c < 1) f = 4'd0;
      else if (c < 3) f = 4'd1;
      else if (c < 5) f = 4'd2;
      else if (c < 25) f = 4'd3;
      else if (c < 28) f = 4'd0;
      else if (c < 30) f = 4'd1;
      else if (c < 32) f = 4'd2;
      else if (c < 38) f = 4'd3;
      else if (c < 41) f = 4'd0;
      else if (c < 43) f = 4'd1;
      else f = 4'd0;
      sb.push_back(ev(1'b0, 1'b0, lk, lk, f, 2'd0));
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL lockout cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // LOCK at cycle 5 of the opening closes the lock early. LOCK in IDLE is
  // ignored.
  task automatic test_early_lock();
    logic [9:0] exp_v;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      clear_inputs();
      if (c == 0) bus_cmd(ADDR, 3'd1);
      if (c == 5 || c == 11) bus_cmd(ADDR, 3'd2);
      sb.push_back(ev(c >= 1 && c <= 5, c == 6, c >= 1 && c <= 9, 1'b0,
                      4'd0, (c >= 1) ? 2'd2 : 2'd0));
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL early_lock cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset during cycle 5 of an opening: all outputs are 0 from the next edge,
  // and no isDone follows.
  task automatic test_reset_mid_open();
    logic [9:0] exp_v;
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      clear_inputs();
      Reset = (c == 5);
      if (c == 0) bus_cmd(ADDR, 3'd1);
      sb.push_back(ev(c >= 1 && c <= 5, 1'b0, c >= 1 && c <= 5, 1'b0, 4'd0,
                      (c >= 1 && c <= 5) ? 2'd2 : 2'd0));
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL reset_mid_open cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    Reset = 1'b0;
  endtask

  // Lockout starts at cycle 5 and the switch rises at cycle 8, so the manual
  // request arrives in cycle 11.
  task automatic test_override();
    logic [9:0] exp_v;
    logic [3:0] f;
    do_reset();
    for (int c = 0; c <= 28; c++) begin
      clear_inputs();
      switch = (c >= 8);
      if (c == 0 || c == 2 || c == 4) keypad(1'b0);
      if (c < 1) f = 4'd0;
      else if (c < 3) f = 4'd1;
      else if (c < 5) f = 4'd2;
`ifdef MANUAL_OVERRIDE_EN
      else if (c < 12) f = 4'd3;
      else f = 4'd0;
      sb.push_back(ev(c >= 12 && c <= 21, c == 22, c >= 5 && c <= 25,
                      c >= 5 && c <= 11, f, (c >= 12) ? 2'd1 : 2'd0));
`else
      else if (c < 25) f = 4'd3;
      else f = 4'd0;
      sb.push_back(ev(1'b0, 1'b0, c >= 5 && c <= 24, c >= 5 && c <= 24, f, 2'd0));
`endif
      @(negedge clk);
      exp_v = sb.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL override cycle %0d: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    switch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bus_unlock();
    test_manual();
    test_priority();
    test_lockout();
    test_early_lock();
    test_reset_mid_open();
    test_override();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
